// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the frame accumulator: FSM state codes and the
// default widths used by the adder benches.
package sum_accumulator_pkg;

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam int DEF_IN_W  = 5;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_N     = 8;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational saturating adder: sign-extends the sample, adds it to the
// accumulator one bit wider than the accumulator, then clamps the result
// to the signed ACC_W range.
module sat_add
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  // Returns {overflow, clamped sum}; the extra top bit of the wide sum
  // disagrees with the ACC_W sign bit exactly when the result left range.
  function automatic logic [ACC_W:0] sat_sum(input logic [ACC_W-1:0] a,
                                             input logic [IN_W-1:0]  b);
    logic [ACC_W:0] wide;
    wide = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      if (wide[ACC_W]) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else             return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, wide[ACC_W-1:0]};
  endfunction

  // Split the packed function result into sum and overflow.
  always_comb begin
    logic [ACC_W:0] r;
    r   = sat_sum(acc, din);
    ovf = r[ACC_W];
    sum = r[ACC_W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator for the adder output: sums N accepted samples with
// saturation, presents the frame total on a valid/ready port, then starts
// the next frame from zero.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_sat
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sat_flag;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_ovf;
  logic                    last_sample;

  sat_add #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_sat_add (
    .acc(acc),
    .din(in_data),
    .sum(acc_next),
    .ovf(acc_ovf)
  );

  assign in_ready    = (state == S_ACC) && !rst;
  assign last_sample = (cnt == CNT_W'(N - 1));

  // Frame FSM: accumulate N samples, hold the total until taken downstream.
  // rst beats clear, and clear beats any accept or output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            if (last_sample) begin
              out_sum   <= acc_next;
              out_sat   <= sat_flag | acc_ovf;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              sat_flag  <= 1'b0;
              state     <= S_HOLD;
            end else begin
              acc      <= acc_next;
              sat_flag <= sat_flag | acc_ovf;
              cnt      <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_ACC;
          end
        end
      endcase
    end
  end

endmodule
